as_dmem_arb: RTL and testbench

Data-memory port arbiter for the rv64i `as_top_mem` system. It shares the single 64-bit synchronous data memory between the core load/store port and the JTAG debug access port using round-robin arbitration. It steers core sub-word accesses (byte, half, word, double; signed/unsigned) onto byte lanes and returns aligned, extended load data one cycle after grant. It sits between the core/debug masters and the data RAM, ahead of GPIO address decode.

---
 rtl/as_pack.sv | 34 +++
 rtl/as_dmem_align.sv | 39 +++
 rtl/as_dmem_arb.sv | 138 +++++++++++++
 tb/tb_as_dmem_arb.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/as_pack.sv
// Shared types for the as_dmem data-memory path: access sizes, response kinds
// and the sub-word helpers used by lane steering and misalignment checks.
package as_pack;

  typedef enum logic [1:0] {MEM_B, MEM_H, MEM_W, MEM_D} mem_size_t;
  typedef enum logic [1:0] {RESP_NONE, RESP_CORE_LD, RESP_DBG_LD, RESP_CORE_ERR} dmem_resp_t;

  localparam int dmem_data_width = 64;

  function automatic logic [7:0] size_mask(input mem_size_t sz);
    logic [7:0] m;
    case (sz)
      MEM_B:   m = 8'h01;
      MEM_H:   m = 8'h03;
      MEM_W:   m = 8'h0F;
      MEM_D:   m = 8'hFF;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  function automatic logic is_misaligned(input mem_size_t sz, input logic [2:0] off);
    logic mis;
    case (sz)
      MEM_B:   mis = 1'b0;
      MEM_H:   mis = off[0];
      MEM_W:   mis = |off[1:0];
      MEM_D:   mis = |off[2:0];
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/as_dmem_align.sv
// Combinational sub-word handling: store byte-lane steering and enables,
// misalignment detection, and load extraction with sign/zero extension.
module as_dmem_align
  import as_pack::*;
(
  input  logic [2:0]                 st_off_i,
  input  mem_size_t                  st_size_i,
  input  logic [dmem_data_width-1:0] st_wdata_i,
  output logic [7:0]                 st_be_o,
  output logic [dmem_data_width-1:0] st_wdata_o,
  output logic                       st_misalign_o,
  input  logic [2:0]                 ld_off_i,
  input  mem_size_t                  ld_size_i,
  input  logic                       ld_unsigned_i,
  input  logic [dmem_data_width-1:0] ld_rdata_i,
  output logic [dmem_data_width-1:0] ld_data_o
);

  logic [dmem_data_width-1:0] shifted;

  // Store steering and load extraction; byte offset selects the lane.
  always_comb begin
    st_be_o       = size_mask(st_size_i) << st_off_i;
    st_wdata_o    = st_wdata_i << {st_off_i, 3'b000};
    st_misalign_o = is_misaligned(st_size_i, st_off_i);
    shifted       = ld_rdata_i >> {ld_off_i, 3'b000};
    case (ld_size_i)
      MEM_B:   ld_data_o = ld_unsigned_i ? {56'd0, shifted[7:0]}
                                         : {{56{shifted[7]}}, shifted[7:0]};
      MEM_H:   ld_data_o = ld_unsigned_i ? {48'd0, shifted[15:0]}
                                         : {{48{shifted[15]}}, shifted[15:0]};
      MEM_W:   ld_data_o = ld_unsigned_i ? {32'd0, shifted[31:0]}
                                         : {{32{shifted[31]}}, shifted[31:0]};
      MEM_D:   ld_data_o = shifted;
      default: ld_data_o = shifted;
    endcase
  end

endmodule

// File: rtl/as_dmem_arb.sv
// Round-robin arbiter sharing one synchronous 64-bit data RAM between the core
// load/store port and the debug port, with a one-cycle response pipeline.
module as_dmem_arb
  import as_pack::*;
#(
  parameter int DADDR_W = 12
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               core_req_i,
  input  logic               core_we_i,
  input  logic [DADDR_W-1:0] core_addr_i,
  input  logic [1:0]         core_size_i,
  input  logic               core_unsigned_i,
  input  logic [63:0]        core_wdata_i,
  output logic               core_gnt_o,
  output logic               core_rvalid_o,
  output logic [63:0]        core_rdata_o,
  output logic               core_err_o,
  input  logic               dbg_req_i,
  input  logic               dbg_we_i,
  input  logic [DADDR_W-1:0] dbg_addr_i,
  input  logic [63:0]        dbg_wdata_i,
  output logic               dbg_gnt_o,
  output logic               dbg_rvalid_o,
  output logic [63:0]        dbg_rdata_o,
  output logic               mem_en_o,
  output logic [7:0]         mem_be_o,
  output logic [DADDR_W-4:0] mem_addr_o,
  output logic [63:0]        mem_wdata_o,
  input  logic [63:0]        mem_rdata_i
);

  logic       last_q, last_d;
  dmem_resp_t resp_q, resp_d;
  logic       err_q, err_d;
  logic [2:0] ld_off_q, ld_off_d;
  mem_size_t  ld_size_q, ld_size_d;
  logic       ld_uns_q, ld_uns_d;

  logic        core_mis, core_ok, dbg_ok, core_win, dbg_win, core_mis_gnt;
  logic [7:0]  st_be;
  logic [63:0] st_wdata, ld_data;
  logic        dbg_addr_unused;

  assign dbg_addr_unused = ^dbg_addr_i[2:0];

  as_dmem_align u_align (
    .st_off_i      (core_addr_i[2:0]),
    .st_size_i     (mem_size_t'(core_size_i)),
    .st_wdata_i    (core_wdata_i),
    .st_be_o       (st_be),
    .st_wdata_o    (st_wdata),
    .st_misalign_o (core_mis),
    .ld_off_i      (ld_off_q),
    .ld_size_i     (ld_size_q),
    .ld_unsigned_i (ld_uns_q),
    .ld_rdata_i    (mem_rdata_i),
    .ld_data_o     (ld_data)
  );

  // Arbitration, RAM port muxing and next-state for the response pipeline.
  // A misaligned core access never claims the RAM, so debug may use it alongside.
  always_comb begin
    core_ok      = core_req_i & ~core_mis & ~rst_i;
    dbg_ok       = dbg_req_i & ~rst_i;
    core_win     = core_ok & (~dbg_ok | last_q);
    dbg_win      = dbg_ok & (~core_ok | ~last_q);
    core_mis_gnt = core_req_i & core_mis & ~rst_i;

    core_gnt_o  = core_win | core_mis_gnt;
    dbg_gnt_o   = dbg_win;
    mem_en_o    = core_win | dbg_win;
    mem_be_o    = 8'h00;
    mem_addr_o  = {(DADDR_W-3){1'b0}};
    mem_wdata_o = 64'd0;
    last_d      = last_q;
    resp_d      = RESP_NONE;
    err_d       = core_mis_gnt;
    ld_off_d    = ld_off_q;
    ld_size_d   = ld_size_q;
    ld_uns_d    = ld_uns_q;

    if (core_win) begin
      last_d     = 1'b0;
      mem_addr_o = core_addr_i[DADDR_W-1:3];
      if (core_we_i) begin
        mem_be_o    = st_be;
        mem_wdata_o = st_wdata;
      end else begin
        resp_d    = RESP_CORE_LD;
        ld_off_d  = core_addr_i[2:0];
        ld_size_d = mem_size_t'(core_size_i);
        ld_uns_d  = core_unsigned_i;
      end
    end else if (dbg_win) begin
      last_d     = 1'b1;
      mem_addr_o = dbg_addr_i[DADDR_W-1:3];
      if (dbg_we_i) begin
        mem_be_o    = 8'hFF;
        mem_wdata_o = dbg_wdata_i;
      end else begin
        resp_d = RESP_DBG_LD;
      end
    end else begin
      last_d = last_q;
    end
  end

  // State and response registers; reset drops any in-flight response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q    <= 1'b1;
      resp_q    <= RESP_NONE;
      err_q     <= 1'b0;
      ld_off_q  <= 3'd0;
      ld_size_q <= MEM_B;
      ld_uns_q  <= 1'b0;
    end else begin
      last_q    <= last_d;
      resp_q    <= resp_d;
      err_q     <= err_d;
      ld_off_q  <= ld_off_d;
      ld_size_q <= ld_size_d;
      ld_uns_q  <= ld_uns_d;
    end
  end

  // Response outputs; data is forced to zero outside its valid cycle.
  always_comb begin
    core_rvalid_o = (resp_q == RESP_CORE_LD);
    dbg_rvalid_o  = (resp_q == RESP_DBG_LD);
    core_err_o    = err_q;
    core_rdata_o  = core_rvalid_o ? ld_data : 64'd0;
    dbg_rdata_o   = dbg_rvalid_o ? mem_rdata_i : 64'd0;
  end

endmodule

// File: tb/tb_as_dmem_arb.sv
// Bench for as_dmem_arb: byte-addressed reference memory plus arbitration model
// checked every cycle, alongside directed vectors with literal expectations.
module tb_as_dmem_arb;
  import as_pack::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we, core_uns;
  logic [11:0] core_addr;
  logic [1:0]  core_size;
  logic [63:0] core_wdata;
  logic        core_gnt_o, core_rvalid_o, core_err_o;
  logic [63:0] core_rdata_o;
  logic        dbg_req, dbg_we;
  logic [11:0] dbg_addr;
  logic [63:0] dbg_wdata;
  logic        dbg_gnt_o, dbg_rvalid_o;
  logic [63:0] dbg_rdata_o;
  logic        mem_en_o;
  logic [7:0]  mem_be_o;
  logic [8:0]  mem_addr_o;
  logic [63:0] mem_wdata_o, mem_rdata;

  int total = 0;
  int bad = 0;

  logic [63:0] ram [0:511];
  logic [7:0]  ref_mem [0:4095];

  logic        p_crv, p_err, p_drv, m_last;
  logic [63:0] p_cdat, p_ddat;
  logic [7:0]  g_be;
  logic [63:0] g_wd;
  logic        g_en;

  always #5 clk = ~clk;

  as_dmem_arb #(.DADDR_W(12)) dut (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
    .core_size_i(core_size), .core_unsigned_i(core_uns), .core_wdata_i(core_wdata),
    .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
    .core_err_o(core_err_o),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_gnt_o(dbg_gnt_o), .dbg_rvalid_o(dbg_rvalid_o), .dbg_rdata_o(dbg_rdata_o),
    .mem_en_o(mem_en_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Synchronous RAM driven by the DUT memory port.
  always @(posedge clk) begin : ram_model
    logic [63:0] w;
    if (mem_en_o) begin
      if (mem_be_o == 8'h00) begin
        mem_rdata <= ram[mem_addr_o];
      end else begin
        w = ram[mem_addr_o];
        for (int i = 0; i < 8; i++)
          if (mem_be_o[i]) w[8*i +: 8] = mem_wdata_o[8*i +: 8];
        ram[mem_addr_o] <= w;
      end
    end
  end

  function automatic logic [63:0] ref_load(input logic [11:0] a, input int n, input logic u);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < n; i++) v = v | (64'(ref_mem[a + 12'(i)]) << (8 * i));
    if (!u && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
    return v;
  endfunction

  // Per-cycle reference model: who must win, what the RAM port must show,
  // and what must come back one cycle later.
  always @(negedge clk) begin : model
    int          n, off;
    logic        mis, cok, cw, dw;
    logic [7:0]  ebe;
    logic [63:0] ewd, lane_mask;
    logic [11:0] dbase;
    if (rst) begin
      chk("rst_core_gnt", core_gnt_o, 64'd0);
      chk("rst_dbg_gnt", dbg_gnt_o, 64'd0);
      chk("rst_mem_en", mem_en_o, 64'd0);
      chk("rst_mem_be", mem_be_o, 64'd0);
      chk("rst_core_rvalid", core_rvalid_o, 64'd0);
      chk("rst_core_rdata", core_rdata_o, 64'd0);
      chk("rst_core_err", core_err_o, 64'd0);
      chk("rst_dbg_rvalid", dbg_rvalid_o, 64'd0);
      chk("rst_dbg_rdata", dbg_rdata_o, 64'd0);
      p_crv = 1'b0; p_err = 1'b0; p_drv = 1'b0; m_last = 1'b1;
      p_cdat = 64'd0; p_ddat = 64'd0;
    end else begin
      chk("core_rvalid", core_rvalid_o, p_crv);
      chk("core_rdata", core_rdata_o, p_crv ? p_cdat : 64'd0);
      chk("core_err", core_err_o, p_err);
      chk("dbg_rvalid", dbg_rvalid_o, p_drv);
      chk("dbg_rdata", dbg_rdata_o, p_drv ? p_ddat : 64'd0);

      n   = 1 << core_size;
      off = int'(core_addr) % 8;
      mis = core_req && (int'(core_addr) % n != 0);
      cok = core_req && !mis;
      cw  = cok && (!dbg_req || m_last);
      dw  = dbg_req && !cw;
      chk("core_gnt", core_gnt_o, cw || mis);
      chk("dbg_gnt", dbg_gnt_o, dw);
      chk("mem_en", mem_en_o, cw || dw);
      if (cw || dw) chk("mem_addr", mem_addr_o, cw ? core_addr / 8 : dbg_addr / 8);

      ebe = 8'h00; ewd = 64'd0;
      if (cw && core_we)
        for (int i = 0; i < n; i++) begin
          ebe[off + i] = 1'b1;
          ewd[8*(off + i) +: 8] = core_wdata[8*i +: 8];
        end
      if (dw && dbg_we) begin
        ebe = 8'hFF; ewd = dbg_wdata;
      end
      chk("mem_be", mem_be_o, ebe);
      lane_mask = 64'd0;
      for (int i = 0; i < 8; i++) if (ebe[i]) lane_mask[8*i +: 8] = 8'hFF;
      chk("mem_wdata", mem_wdata_o & lane_mask, ewd);

      dbase  = dbg_addr & 12'hFF8;
      p_err  = mis;
      p_crv  = cw && !core_we;
      p_cdat = ref_load(core_addr, n, core_uns);
      p_drv  = dw && !dbg_we;
      p_ddat = ref_load(dbase, 8, 1'b1);
      if (cw && core_we)
        for (int i = 0; i < n; i++) ref_mem[core_addr + 12'(i)] = core_wdata[8*i +: 8];
      if (dw && dbg_we)
        for (int i = 0; i < 8; i++) ref_mem[dbase + 12'(i)] = dbg_wdata[8*i +: 8];
      if (cw) m_last = 1'b0;
      else if (dw) m_last = 1'b1;
    end
  end

  task automatic core_op(input logic we, input logic [11:0] a, input logic [1:0] sz,
                         input logic u, input logic [63:0] wd);
    logic got;
    got = 1'b0;
    core_req = 1'b1; core_we = we; core_addr = a; core_size = sz; core_uns = u; core_wdata = wd;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (core_gnt_o) begin
        got = 1'b1; g_be = mem_be_o; g_wd = mem_wdata_o; g_en = mem_en_o;
      end
    end
    chk("core_gnt_wait", got, 64'd1);
    @(posedge clk); #1;
    core_req = 1'b0;
  endtask

  task automatic dbg_op(input logic we, input logic [11:0] a, input logic [63:0] wd);
    logic got;
    got = 1'b0;
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = wd;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (dbg_gnt_o) got = 1'b1;
    end
    chk("dbg_gnt_wait", got, 64'd1);
    @(posedge clk); #1;
    dbg_req = 1'b0;
  endtask

  task automatic core_ld(input string name, input logic [11:0] a, input logic [1:0] sz,
                         input logic u, input logic [63:0] exp);
    core_op(1'b0, a, sz, u, 64'd0);
    @(negedge clk);
    chk({name, "_rvalid"}, core_rvalid_o, 64'd1);
    chk(name, core_rdata_o, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    core_req = 1'b0; core_we = 1'b0; core_addr = 12'd0; core_size = 2'd0;
    core_uns = 1'b0; core_wdata = 64'd0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 12'd0; dbg_wdata = 64'd0;
    mem_rdata = 64'd0;
    for (int i = 0; i < 512; i++) ram[i] = 64'd0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    core_op(1'b1, 12'h005, 2'd0, 1'b0, 64'hAB);
    chk("sb_en", g_en, 64'd1);
    chk("sb_be", g_be, 64'h20);
    chk("sb_lane", g_wd[47:40], 64'hAB);
    core_ld("lbu_05", 12'h005, 2'd0, 1'b1, 64'h00000000000000AB);
    core_op(1'b1, 12'h001, 2'd0, 1'b0, 64'h80);
    core_ld("lb_01", 12'h001, 2'd0, 1'b0, 64'hFFFFFFFFFFFFFF80);

    core_op(1'b1, 12'h004, 2'd2, 1'b0, 64'h80001234);
    chk("sw_be", g_be, 64'hF0);
    core_ld("lw_04", 12'h004, 2'd2, 1'b0, 64'hFFFFFFFF80001234);
    core_ld("lwu_04", 12'h004, 2'd2, 1'b1, 64'h0000000080001234);
    core_ld("lhu_06", 12'h006, 2'd1, 1'b1, 64'h0000000000008000);

    // Misaligned lh alongside a debug read of the same cycle.
    core_req = 1'b1; core_we = 1'b0; core_addr = 12'h003; core_size = 2'd1; core_uns = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 12'h010;
    @(negedge clk);
    chk("mis_core_gnt", core_gnt_o, 64'd1);
    chk("mis_dbg_gnt", dbg_gnt_o, 64'd1);
    chk("mis_mem_en", mem_en_o, 64'd1);
    chk("mis_mem_addr", mem_addr_o, 64'd2);
    @(posedge clk); #1;
    core_req = 1'b0; dbg_req = 1'b0;
    @(negedge clk);
    chk("mis_err", core_err_o, 64'd1);
    chk("mis_no_rvalid", core_rvalid_o, 64'd0);
    chk("mis_dbg_rvalid", dbg_rvalid_o, 64'd1);
    @(negedge clk);
    chk("mis_err_pulse", core_err_o, 64'd0);
    @(posedge clk); #1;

    dbg_op(1'b1, 12'h010, 64'h0123456789ABCDEF);
    core_ld("ld_10", 12'h010, 2'd3, 1'b0, 64'h0123456789ABCDEF);
    dbg_op(1'b0, 12'h017, 64'd0);
    @(negedge clk);
    chk("dbg_rd_10", dbg_rdata_o, 64'h0123456789ABCDEF);
    @(posedge clk); #1;

    // Reset one cycle after a load grant; requests held through reset.
    core_op(1'b0, 12'h010, 2'd3, 1'b0, 64'd0);
    rst = 1'b1;
    core_req = 1'b1; core_we = 1'b0; core_addr = 12'h010; core_size = 2'd3; core_uns = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 12'h008;
    @(negedge clk);
    chk("rst_drop_rvalid", core_rvalid_o, 64'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rr_core_gnt", core_gnt_o, (i % 2 == 0) ? 64'd1 : 64'd0);
      chk("rr_dbg_gnt", dbg_gnt_o, (i % 2 == 1) ? 64'd1 : 64'd0);
      if (i > 0) begin
        chk("rr_core_rvalid", core_rvalid_o, (i % 2 == 1) ? 64'd1 : 64'd0);
        chk("rr_dbg_rvalid", dbg_rvalid_o, (i % 2 == 0) ? 64'd1 : 64'd0);
      end
      if (i == 1) chk("rr_core_rdata", core_rdata_o, 64'h0123456789ABCDEF);
      @(posedge clk); #1;
    end
    core_req = 1'b0; dbg_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
